// File: rtl/cpu_fetch_stage.sv
// Moxie instruction-fetch stage: streams imem words into a halfword prefetch FIFO,
// assembles 16-bit opcodes with optional 32-bit immediates and presents one per cycle.
module cpu_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_1000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        stall_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] imem_address_o,
    output logic [15:0] opcode,
    output logic [31:0] operand,
    output logic        valid,
    output logic [31:0] PC_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [15:0] fifo_q [FIFO_DEPTH];
    ptr_t        rd_ptr_q, wr_ptr_q;
    cnt_t        count_q;
    logic [31:0] fetch_addr_q, dec_pc_q;
    logic        inflight_q, drop_hi_q;
    logic [15:0] opcode_q;
    logic [31:0] operand_q, pc_q;
    logic        valid_q;

    logic [15:0] h0, h1, h2;
    logic        head_long, complete, pop, issue, push_en;
    cnt_t        pop_n, push_n, free_slots;

    function automatic logic is_long(input logic [15:0] h);
        if (h[15]) return 1'b0;
        case (h[15:8])
            8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
            8'h1F, 8'h20, 8'h22, 8'h24, 8'h30, 8'h36, 8'h37, 8'h38, 8'h39:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        h0         = fifo_q[rd_ptr_q];
        h1         = fifo_q[rd_ptr_q + ptr_t'(1)];
        h2         = fifo_q[rd_ptr_q + ptr_t'(2)];
        head_long  = is_long(h0);
        complete   = (count_q >= cnt_t'(3)) || ((count_q != '0) && !head_long);
        pop        = !branch_flag_i && !stall_i && complete;
        pop_n      = '0;
        if (pop) pop_n = head_long ? cnt_t'(3) : cnt_t'(1);
        push_en    = inflight_q && !rst_i && !branch_flag_i;
        push_n     = '0;
        if (inflight_q) push_n = drop_hi_q ? cnt_t'(1) : cnt_t'(2);
        free_slots = cnt_t'(FIFO_DEPTH) - count_q;
        // Reserve room for the word already in flight plus the one about to be requested.
        issue      = !branch_flag_i &&
                     (free_slots >= (inflight_q ? cnt_t'(4) : cnt_t'(2)));
    end

    // NOTE: the FIFO storage is not reset; count_q and the pointers alone define its contents.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            if (drop_hi_q) begin
                fifo_q[wr_ptr_q] <= imem_data_i[15:0];
            end else begin
                fifo_q[wr_ptr_q]              <= imem_data_i[31:16];
                fifo_q[wr_ptr_q + ptr_t'(1)]  <= imem_data_i[15:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            inflight_q   <= 1'b0;
            drop_hi_q    <= RESET_PC[1];
            fetch_addr_q <= RESET_PC & ~32'd3;
            dec_pc_q     <= RESET_PC;
            opcode_q     <= '0;
            operand_q    <= '0;
            pc_q         <= '0;
            valid_q      <= 1'b0;
        end else if (branch_flag_i) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            inflight_q   <= 1'b0;
            drop_hi_q    <= branch_target_i[1];
            fetch_addr_q <= branch_target_i & ~32'd3;
            dec_pc_q     <= branch_target_i & ~32'd1;
            valid_q      <= 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr_q  <= wr_ptr_q + ptr_t'(push_n);
                drop_hi_q <= 1'b0;
            end
            rd_ptr_q   <= rd_ptr_q + ptr_t'(pop_n);
            count_q    <= count_q - pop_n + push_n;
            inflight_q <= issue;
            if (issue) fetch_addr_q <= fetch_addr_q + 32'd4;
            if (!stall_i) begin
                valid_q <= complete;
                if (complete) begin
                    opcode_q  <= h0;
                    operand_q <= head_long ? {h1, h2} : 32'd0;
                    pc_q      <= dec_pc_q;
                    dec_pc_q  <= dec_pc_q + (head_long ? 32'd6 : 32'd2);
                end
            end
        end
    end

    assign imem_address_o = fetch_addr_q;
    assign opcode         = opcode_q;
    assign operand        = operand_q;
    assign valid          = valid_q;
    assign PC_o           = pc_q;

endmodule

// File: tb/tb_cpu_fetch_stage.sv
// Scoreboard bench for cpu_fetch_stage: directed program, stall, branch and reset scenarios
// with a 1-cycle-latency instruction memory model.
module tb_cpu_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        stall_i;
    logic [31:0] imem_data_i;
    logic [31:0] imem_address_o;
    logic [15:0] opcode;
    logic [31:0] operand;
    logic        valid;
    logic [31:0] PC_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] op;
        logic [31:0] imm;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   consumed = 0;

    cpu_fetch_stage #(.RESET_PC(32'h0000_1000), .FIFO_DEPTH(8)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .stall_i         (stall_i),
        .imem_data_i     (imem_data_i),
        .imem_address_o  (imem_address_o),
        .opcode          (opcode),
        .operand         (operand),
        .valid           (valid),
        .PC_o            (PC_o)
    );

    always #5 clk_i = ~clk_i;

    // Program image; everything outside the hand-written block is short opcodes 0x4nnn.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [11:0] lo;
        lo = a[11:0];
        case (a)
            32'h1000: return 32'h0100_0000;
            32'h1004: return 32'h1234_2F00;
            32'h1008: return 32'h0510_0520;
            32'h100C: return 32'h0530_0900;
            32'h1010: return 32'hABCD_EF01;
            default:  return {4'h4, lo, 4'h4, lo + 12'd2};
        endcase
    endfunction

    always @(posedge clk_i) imem_data_i <= mem_word(imem_address_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [15:0] op, input logic [31:0] imm);
        exp_t e;
        e.pc  = pc;
        e.op  = op;
        e.imm = imm;
        exp_q.push_back(e);
    endtask

    task automatic push_reset_program();
        logic [31:0] pc;
        push_exp(32'h1000, 16'h0100, 32'h0000_1234);
        push_exp(32'h1006, 16'h2F00, 32'h0);
        push_exp(32'h1008, 16'h0510, 32'h0);
        push_exp(32'h100A, 16'h0520, 32'h0);
        push_exp(32'h100C, 16'h0530, 32'h0);
        push_exp(32'h100E, 16'h0900, 32'hABCD_EF01);
        for (int k = 0; k < 80; k++) begin
            pc = 32'h1014 + 32'(2 * k);
            push_exp(pc, {4'h4, pc[11:0]}, 32'h0);
        end
    endtask

    // Monitor: an instruction is consumed when presented with no stall, branch or reset.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i && !branch_flag_i && !stall_i && valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pc", PC_o, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                consumed++;
                check("sb_pc", PC_o, e.pc);
                check("sb_opcode", {16'h0, opcode}, {16'h0, e.op});
                check("sb_operand", operand, e.imm);
            end
        end
    end

    task automatic wait_first_valid(output int cycles);
        cycles = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_i);
            if (valid) begin
                cycles = k;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        int          vcount;
        logic [31:0] snap_pc, snap_imm;
        logic [15:0] snap_op;

        rst_i = 1'b1; branch_flag_i = 1'b0; branch_target_i = '0; stall_i = 1'b0;
        push_reset_program();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_valid", {31'h0, valid}, 32'h0);
        check("reset_addr", imem_address_o, 32'h1000);
        check("reset_pc", PC_o, 32'h0);
        check("reset_opcode", {16'h0, opcode}, 32'h0);
        check("reset_operand", operand, 32'h0);

        // Long head instruction needs two returned words: first valid after 4 edges.
        wait_first_valid(lat);
        check("first_valid_latency", lat, 4);

        vcount = 0;
        repeat (12) begin
            @(negedge clk_i);
            if (valid) vcount++;
        end
        check("steady_one_per_cycle", vcount, 12);

        // Stall for three edges; outputs must not move.
        @(posedge clk_i); #1;
        stall_i = 1'b1;
        @(negedge clk_i);
        snap_pc = PC_o; snap_op = opcode; snap_imm = operand;
        check("stall_valid_start", {31'h0, valid}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("stall_frozen_pc", PC_o, snap_pc);
            check("stall_frozen_opcode", {16'h0, opcode}, {16'h0, snap_op});
            check("stall_frozen_operand", operand, snap_imm);
            check("stall_frozen_valid", {31'h0, valid}, 32'h1);
            if (k == 1) begin
                @(posedge clk_i); #1;
                stall_i = 1'b0;
            end
        end

        repeat (8) @(negedge clk_i);

        // Branch to 0x2002 while stalled.
        @(posedge clk_i); #1;
        stall_i = 1'b1;
        @(posedge clk_i); #1;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h2002;
        exp_q.delete();
        for (int k = 0; k < 60; k++)
            push_exp(32'h2002 + 32'(2 * k), 16'h4002 + 16'(2 * k), 32'h0);
        @(posedge clk_i); #1;
        branch_flag_i = 1'b0;
        stall_i       = 1'b0;
        @(negedge clk_i);
        check("branch_valid_low", {31'h0, valid}, 32'h0);
        wait_first_valid(lat);
        check("branch_latency_min", {31'h0, lat >= 2}, 32'h1);
        check("branch_first_pc", PC_o, 32'h2002);
        check("branch_first_opcode", {16'h0, opcode}, 32'h4002);

        repeat (10) @(negedge clk_i);

        // Reset mid-stream restarts at RESET_PC.
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        exp_q.delete();
        push_reset_program();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midreset_valid", {31'h0, valid}, 32'h0);
        check("midreset_addr", imem_address_o, 32'h1000);
        wait_first_valid(lat);
        check("midreset_latency", lat, 4);
        repeat (10) @(negedge clk_i);

        check("consumed_min", {31'h0, consumed >= 30}, 32'h1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
